// File: rtl/multi_rem.sv
// Sequential 3-bit multiply (shift-add) / remainder (restoring divide) unit with start/done handshake.
// Optional macro REM_QUOTIENT_EN adds a registered quotient output.
module multi_rem (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sel,
  input  logic [2:0] num1,
  input  logic [2:0] num2,
  output logic       busy,
  output logic       done,
  output logic [5:0] result,
  output logic       zeroFlag,
  output logic       divByZeroFlag
`ifdef REM_QUOTIENT_EN
  ,
  output logic [2:0] quotient
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        op_q;
  logic [5:0]  a_q;
  logic [5:0]  a_d;
  logic [2:0]  b_q;
  logic [2:0]  b_d;
  logic [5:0]  acc_q;
  logic [5:0]  acc_d;
  logic        busy_q;
  logic        done_q;
  logic [5:0]  result_q;
  logic        zero_q;
  logic        dbz_q;
  logic [3:0]  trial_s;
  logic [3:0]  diff_s;
  logic        dbz_s;
  logic        zero_s;
  logic [5:0]  res_s;
`ifdef REM_QUOTIENT_EN
  logic [2:0]  quo_q;
  logic [2:0]  quo_d;
  logic [2:0]  quotient_q;
  logic [2:0]  quo_res_s;
`endif

  // One iteration: multiply consumes multiplier LSB-first, divide consumes numerator MSB-first
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    trial_s = {acc_q[2:0], a_q[2]};
    diff_s  = trial_s - {1'b0, b_q};
`ifdef REM_QUOTIENT_EN
    quo_d   = quo_q;
`endif
    if (op_q == 1'b0) begin
      if (b_q[0]) begin
        acc_d = acc_q + a_q;
      end else begin
        acc_d = acc_q;
      end
      a_d = {a_q[4:0], 1'b0};
      b_d = {1'b0, b_q[2:1]};
    end else begin
      if (trial_s >= {1'b0, b_q}) begin
        acc_d = {2'b00, diff_s};
`ifdef REM_QUOTIENT_EN
        quo_d = {quo_q[1:0], 1'b1};
`endif
      end else begin
        acc_d = {2'b00, trial_s};
`ifdef REM_QUOTIENT_EN
        quo_d = {quo_q[1:0], 1'b0};
`endif
      end
      a_d = {a_q[4:0], 1'b0};
    end
  end

  // Final result and flags; a zero divisor forces the result to zero
  always_comb begin
    dbz_s = op_q & (b_q == 3'd0);
    if (dbz_s) begin
      res_s = 6'd0;
    end else if (op_q) begin
      res_s = {3'b000, acc_q[2:0]};
    end else begin
      res_s = acc_q;
    end
    zero_s = ~dbz_s & (res_s == 6'd0);
`ifdef REM_QUOTIENT_EN
    if (op_q && !dbz_s) begin
      quo_res_s = quo_q;
    end else begin
      quo_res_s = 3'd0;
    end
`endif
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      op_q     <= 1'b0;
      a_q      <= 6'd0;
      b_q      <= 3'd0;
      acc_q    <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 6'd0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef REM_QUOTIENT_EN
      quo_q      <= 3'd0;
      quotient_q <= 3'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            op_q    <= sel;
            a_q     <= {3'b000, num1};
            b_q     <= num2;
            acc_q   <= 6'd0;
            cnt_q   <= 2'd0;
`ifdef REM_QUOTIENT_EN
            quo_q   <= 3'd0;
`endif
          end
        end
        CALC: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q + 2'd1;
`ifdef REM_QUOTIENT_EN
          quo_q <= quo_d;
`endif
          if (cnt_q == 2'd2) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          result_q <= res_s;
          zero_q   <= zero_s;
          dbz_q    <= dbz_s;
`ifdef REM_QUOTIENT_EN
          quotient_q <= quo_res_s;
`endif
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign zeroFlag      = zero_q;
  assign divByZeroFlag = dbz_q;
`ifdef REM_QUOTIENT_EN
  assign quotient      = quotient_q;
`endif

endmodule

// File: tb/tb_multi_rem.sv
// Scoreboard bench for multi_rem: directed corner cases plus random operations vs. an arithmetic model.
module tb_multi_rem;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sel;
  logic [2:0] num1;
  logic [2:0] num2;
  logic       busy;
  logic       done;
  logic [5:0] result;
  logic       zeroFlag;
  logic       divByZeroFlag;
`ifdef REM_QUOTIENT_EN
  logic [2:0] quotient;
`endif

  multi_rem dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .num1(num1), .num2(num2),
    .busy(busy), .done(done), .result(result), .zeroFlag(zeroFlag),
    .divByZeroFlag(divByZeroFlag)
`ifdef REM_QUOTIENT_EN
    , .quotient(quotient)
`endif
  );

  typedef struct {
    int res;
    int z;
    int dz;
    int q;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_res = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic
  function automatic exp_t model(input int s, input int a, input int b, input int c);
    exp_t e;
    e.cyc = c;
    e.dz  = 0;
    e.q   = 0;
    if (s == 0) begin
      e.res = a * b;
    end else if (b == 0) begin
      e.res = 0;
      e.dz  = 1;
    end else begin
      e.res = a % b;
      e.q   = a / b;
    end
    e.z = (e.dz == 0 && e.res == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic issue(input logic s, input logic [2:0] a, input logic [2:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    sel   = s;
    num1  = a;
    num2  = b;
    start = 1'b1;
    sb.push_back(model(int'(s), int'(a), int'(b), cyc + 5));
    @(negedge clk);
    start = 1'b0;
    sel   = 1'($urandom);
    num1  = 3'($urandom);
    num2  = 3'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: every done must match the oldest expectation, on time
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done) begin
          chk("busy_with_done", int'(busy), 0);
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("result", int'(result), e.res);
            chk("zeroFlag", int'(zeroFlag), e.z);
            chk("divByZeroFlag", int'(divByZeroFlag), e.dz);
`ifdef REM_QUOTIENT_EN
            chk("quotient", int'(quotient), e.q);
`endif
            last_res = e.res;
          end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
          chk("done_missing", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    num1  = 3'd0;
    num2  = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_zero", int'(zeroFlag), 0);
    chk("rst_dbz", int'(divByZeroFlag), 0);
    rst_n = 1'b1;

    issue(1'b0, 3'd7, 3'd7);
    issue(1'b0, 3'd5, 3'd0);
    issue(1'b1, 3'd7, 3'd3);
    issue(1'b1, 3'd6, 3'd3);
    issue(1'b1, 3'd5, 3'd0);
    drain();

    // Second start and operand change mid-operation must be ignored
    issue(1'b0, 3'd6, 3'd3);
    sel   = 1'b1;
    num1  = 3'd7;
    num2  = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("hold_result", int'(result), 18);
    chk("hold_last", int'(result), last_res);

    // Reset in the middle of an operation aborts it
    issue(1'b0, 3'd7, 3'd7);
    drain();
    issue(1'b0, 3'd3, 3'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_zero", int'(zeroFlag), 0);
    chk("abort_dbz", int'(divByZeroFlag), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_result_after", int'(result), 0);
    issue(1'b1, 3'd7, 3'd2);
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom), 3'($urandom), 3'($urandom_range(0, 7)));
    end
    drain();
    repeat (3) @(negedge clk);
    chk("final_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
